// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 codes,
// FSM state type and the iteration-count helper.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Wide enough to hold 64 iterations.
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    // Number of CALC cycles for an operation of the given width.
    function automatic logic [CNT_W-1:0] calc_iter(input int xlen, input int unroll,
                                                   input logic is_word);
        int w;
        w = is_word ? 32 : xlen;
        return CNT_W'(w / unroll);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step: MSB-first shift-add for multiply, restoring trial
// subtraction for divide. Chained UNROLL times inside the unit.
module muldiv_step #(
    parameter int XLEN = 64
) (
    input  logic              i_is_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_sh,
    input  logic [XLEN-1:0]   i_op,
    output logic [2*XLEN-1:0] o_acc,
    output logic [XLEN-1:0]   o_sh
);

    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_diff;
    logic          w_ge;

    // Divide: shift next dividend bit into the remainder, keep the difference
    // when it does not borrow. Multiply: double the product, add the multiplicand
    // when the current multiplier MSB is set.
    always_comb begin
        w_rem_sh = {i_acc[XLEN-1:0], i_sh[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, i_op};
        w_ge     = ~w_diff[XLEN];
        if (i_is_div) begin
            o_acc = {{XLEN{1'b0}}, (w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0])};
            o_sh  = {i_sh[XLEN-2:0], w_ge};
        end else begin
            o_acc = {i_acc[2*XLEN-2:0], 1'b0}
                  + (i_sh[XLEN-1] ? {{XLEN{1'b0}}, i_op} : {(2*XLEN){1'b0}});
            o_sh  = {i_sh[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit with valid/ready request and result.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// CALC  | running UNROLL radix-2 steps per cycle on operand magnitudes
// FIX   | sign correction and result selection
// DONE  | result held with res_valid until res_ready
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            PCrst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int PW = 2 * XLEN;

    state_t           r_state;
    logic [2:0]       r_f3;
    logic             r_word;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic [PW-1:0]    r_acc;
    logic [XLEN-1:0]  r_sh;
    logic [XLEN-1:0]  r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_result;
    logic             r_res_valid;
    logic             r_req_ready;
    logic             r_busy;

    logic            w_word, w_is_div, w_sgn_a, w_sgn_b, w_a_neg, w_b_neg, w_dz, w_ovf;
    logic [XLEN-1:0] w_a_sx, w_b_sx, w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min;
    logic [XLEN-1:0] w_fast, w_sh_init, w_op_init;
    logic [PW-1:0]   w_prod;
    logic [XLEN-1:0] w_quo, w_rem, w_fix;

    logic [PW-1:0]   w_acc_ch [UNROLL+1];
    logic [XLEN-1:0] w_sh_ch  [UNROLL+1];

    assign w_acc_ch[0] = r_acc;
    assign w_sh_ch[0]  = r_sh;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .i_is_div (r_f3[2]),
            .i_acc    (w_acc_ch[g]),
            .i_sh     (w_sh_ch[g]),
            .i_op     (r_op),
            .o_acc    (w_acc_ch[g+1]),
            .o_sh     (w_sh_ch[g+1])
        );
    end

    // Request decode: operand extension, magnitudes, fast-path detection.
    always_comb begin
        w_word   = (XLEN == 64) && is_word;
        w_is_div = funct3[2];
        w_sgn_a  = w_is_div ? ~funct3[0] : (funct3 != F3_MULHU);
        w_sgn_b  = w_is_div ? ~funct3[0] : ~funct3[1];
        w_a_sx   = w_word ? XLEN'($signed(A[31:0])) : A;
        w_b_sx   = w_word ? XLEN'($signed(B[31:0])) : B;
        w_a_ext  = (w_word && !w_sgn_a) ? XLEN'(A[31:0]) : w_a_sx;
        w_b_ext  = (w_word && !w_sgn_b) ? XLEN'(B[31:0]) : w_b_sx;
        w_a_neg  = w_sgn_a & w_a_ext[XLEN-1];
        w_b_neg  = w_sgn_b & w_b_ext[XLEN-1];
        w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
        w_min    = w_word ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
        w_dz     = w_is_div && (w_b_ext == '0);
        w_ovf    = w_is_div && w_sgn_a && (w_a_ext == w_min) && (w_b_ext == '1);
        if (w_dz) begin
            w_fast = funct3[1] ? w_a_sx : '1;
        end else begin
            w_fast = funct3[1] ? '0 : w_a_sx;
        end
        // Word operands are pre-aligned to the top so 32 MSB-first steps consume them.
        w_sh_init = (w_is_div ? w_a_mag : w_b_mag) << (w_word ? (XLEN - 32) : 0);
        w_op_init = w_is_div ? w_b_mag : w_a_mag;
    end

    // Sign correction and result selection used in FIX.
    always_comb begin
        w_prod = r_neg_res ? -r_acc : r_acc;
        w_quo  = r_neg_res ? -r_sh : r_sh;
        w_rem  = r_neg_rem ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        case (r_f3)
            F3_MUL:
                w_fix = r_word ? XLEN'($signed(w_prod[31:0])) : w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:
                w_fix = r_word ? XLEN'($signed(w_prod[63:32])) : w_prod[PW-1:XLEN];
            F3_DIV, F3_DIVU:
                w_fix = r_word ? XLEN'($signed(w_quo[31:0])) : w_quo;
            default:
                w_fix = r_word ? XLEN'($signed(w_rem[31:0])) : w_rem;
        endcase
    end

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (PCrst) begin
            r_state     <= IDLE;
            r_f3        <= '0;
            r_word      <= 1'b0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_acc       <= '0;
            r_sh        <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_f3        <= funct3;
                        r_word      <= w_word;
                        r_neg_res   <= w_a_neg ^ w_b_neg;
                        r_neg_rem   <= w_a_neg;
                        r_acc       <= '0;
                        r_sh        <= w_sh_init;
                        r_op        <= w_op_init;
                        r_cnt       <= calc_iter(XLEN, UNROLL, w_word);
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_dz || w_ovf) begin
                            r_result    <= w_fast;
                            r_res_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_acc_ch[UNROLL];
                    r_sh  <= w_sh_ch[UNROLL];
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_result    <= w_fix;
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign res_valid = r_res_valid;
    assign result    = r_result;
    assign busy      = r_busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: two instances (UNROLL=1 and UNROLL=4) share
// stimulus; results and latencies are checked against an arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        PCrst;
    logic        req_valid;
    logic [2:0]  funct3;
    logic        is_word;
    logic [63:0] A, B;
    logic        res_ready;

    logic        rr1, rv1, busy1, rr4, rv4, busy4;
    logic [63:0] res1, res4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(64), .UNROLL(1)) u_dut1 (
        .clk(clk), .PCrst(PCrst), .req_valid(req_valid), .req_ready(rr1),
        .funct3(funct3), .is_word(is_word), .A(A), .B(B),
        .res_valid(rv1), .res_ready(res_ready), .result(res1), .busy(busy1)
    );

    muldiv_unit #(.XLEN(64), .UNROLL(4)) u_dut4 (
        .clk(clk), .PCrst(PCrst), .req_valid(req_valid), .req_ready(rr4),
        .funct3(funct3), .is_word(is_word), .A(A), .B(B),
        .res_valid(rv4), .res_ready(res_ready), .result(res4), .busy(busy4)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat1;
        int          lat4;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Architectural result from RISC-V M rules using plain arithmetic.
    function automatic logic [63:0] ref_res(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] pa, pb, p;
        longint          sa, sb;
        longint unsigned ua, ub;
        int              sa32, sb32;
        int unsigned     ua32, ub32;
        if (!f3[2]) begin
            pa = (f3 == 3'b011) ? $signed({64'd0, a}) : $signed({{64{a[63]}}, a});
            pb = (f3[1] == 1'b0) ? $signed({{64{b[63]}}, b}) : $signed({64'd0, b});
            p  = pa * pb;
            if (f3 == 3'b000) return w ? sx32(p[31:0]) : p[63:0];
            return p[127:64];
        end
        if (w) begin
            sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
            case (f3)
                3'b100: begin
                    if (sb32 == 0) return '1;
                    if (a[31:0] == 32'h8000_0000 && sb32 == -1) return sx32(a[31:0]);
                    return sx32(32'(sa32 / sb32));
                end
                3'b101: return (ub32 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : sx32(ua32 / ub32);
                3'b110: begin
                    if (sb32 == 0) return sx32(a[31:0]);
                    if (a[31:0] == 32'h8000_0000 && sb32 == -1) return 64'd0;
                    return sx32(32'(sa32 % sb32));
                end
                default: return (ub32 == 0) ? sx32(a[31:0]) : sx32(ua32 % ub32);
            endcase
        end
        sa = a; sb = b; ua = a; ub = b;
        case (f3)
            3'b100: begin
                if (sb == 0) return '1;
                if (a == 64'h8000_0000_0000_0000 && sb == -1) return a;
                return 64'(sa / sb);
            end
            3'b101: return (ub == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ua / ub;
            3'b110: begin
                if (sb == 0) return a;
                if (a == 64'h8000_0000_0000_0000 && sb == -1) return 64'd0;
                return 64'(sa % sb);
            end
            default: return (ub == 0) ? a : ua % ub;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        if (!f3[2]) return 1'b0;
        if (w) begin
            if (b[31:0] == 32'd0) return 1'b1;
            return !f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
        end
        if (b == 64'd0) return 1'b1;
        return !f3[0] && a == 64'h8000_0000_0000_0000 && b == '1;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                   input logic [63:0] a, input logic [63:0] b, input int u);
        if (is_fast(f3, w, a, b)) return 1;
        return (w ? 32 : 64) / u + 2;
    endfunction

    function automatic logic [63:0] rand_op();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 20));
            4: return {$urandom(), 32'h8000_0000};
            5: return {$urandom(), 32'hFFFF_FFFF};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Issue one request; latency counts the accepting cycle as cycle 1.
    task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input bit ack,
                          output logic [63:0] r1, output logic [63:0] r4,
                          output int l1, output int l4, output bit busy_ok);
        int cyc;
        bit g1, g4;
        g1 = 0; g4 = 0; l1 = -1; l4 = -1; r1 = '0; r4 = '0; busy_ok = 1;
        cyc = 0;
        while (!(rr1 && rr4) && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        chk("req_ready_before_issue", 64'(rr1 && rr4), 64'd1);
        funct3 = f3; is_word = w; A = a; B = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!(g1 && g4) && cyc < 200) begin
            if (rv1 && !g1) begin g1 = 1; l1 = cyc; r1 = res1; end
            if (rv4 && !g4) begin g4 = 1; l4 = cyc; r4 = res4; end
            if (!busy1 || !busy4) busy_ok = 0;
            if (!(g1 && g4)) begin
                @(posedge clk); #1; cyc++;
            end
        end
        if (!(g1 && g4)) begin
            n_tests++; n_fail++;
            $display("FAIL result_timeout: got no res_valid after %0d cycles expected within 200", cyc);
        end
        if (ack) begin
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] r1, r4, e;
        int          l1, l4;
        bit          bok, seen;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a, b;

        PCrst = 1'b1; req_valid = 1'b0; funct3 = '0; is_word = 1'b0;
        A = '0; B = '0; res_ready = 1'b0;

        vecs[0] = '{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 18};
        vecs[1] = '{3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 18};
        vecs[2] = '{3'b001, 1'b0, '1, '1, 64'd0, 66, 18};
        vecs[3] = '{3'b101, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1};
        vecs[4] = '{3'b110, 1'b0, 64'd100, 64'd0, 64'd100, 1, 1};
        vecs[5] = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 1};
        vecs[6] = '{3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 1};
        vecs[7] = '{3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 10};
        vecs[8] = '{3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 10};
        vecs[9] = '{3'b010, 1'b0, '1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 66, 18};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready1", 64'(rr1), 64'd1);
        chk("rst_res_valid1", 64'(rv1), 64'd0);
        chk("rst_result1", res1, 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_req_ready4", 64'(rr4), 64'd1);
        chk("rst_res_valid4", 64'(rv4), 64'd0);
        chk("rst_result4", res4, 64'd0);
        chk("rst_busy4", 64'(busy4), 64'd0);
        PCrst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, 1'b1, r1, r4, l1, l4, bok);
            chk($sformatf("vec%0d_result_u1", i), r1, vecs[i].exp);
            chk($sformatf("vec%0d_result_u4", i), r4, vecs[i].exp);
            chk($sformatf("vec%0d_latency_u1", i), 64'(l1), 64'(vecs[i].lat1));
            chk($sformatf("vec%0d_latency_u4", i), 64'(l4), 64'(vecs[i].lat4));
            chk($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
        end

        // Backpressure: hold the result while a new request waits.
        run_op(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, r1, r4, l1, l4, bok);
        funct3 = 3'b101; is_word = 1'b0; A = 64'd100; B = 64'd0; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_result1", k), res1, 64'hFFFF_FFFF_FFFF_FFEB);
            chk($sformatf("bp%0d_result4", k), res4, 64'hFFFF_FFFF_FFFF_FFEB);
            chk($sformatf("bp%0d_res_valid", k), 64'(rv1 && rv4), 64'd1);
            chk($sformatf("bp%0d_req_ready", k), 64'(rr1 || rr4), 64'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bp_after_ack_res_valid", 64'(rv1 || rv4), 64'd0);
        chk("bp_after_ack_req_ready", 64'(rr1 && rr4), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_next_res_valid", 64'(rv1 && rv4), 64'd1);
        chk("bp_next_result1", res1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("bp_next_result4", res4, 64'hFFFF_FFFF_FFFF_FFFF);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Reset with UNROLL=1 mid-CALC and UNROLL=4 already in DONE.
        funct3 = 3'b000; is_word = 1'b0; A = 64'd7; B = 64'hFFFF_FFFF_FFFF_FFFD; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("pre_rst_busy1", 64'(busy1), 64'd1);
        chk("pre_rst_res_valid1", 64'(rv1), 64'd0);
        chk("pre_rst_res_valid4", 64'(rv4), 64'd1);
        PCrst = 1'b1;
        @(posedge clk); #1;
        PCrst = 1'b0;
        chk("mid_rst_res_valid1", 64'(rv1), 64'd0);
        chk("mid_rst_result1", res1, 64'd0);
        chk("mid_rst_req_ready1", 64'(rr1), 64'd1);
        chk("mid_rst_busy1", 64'(busy1), 64'd0);
        chk("mid_rst_res_valid4", 64'(rv4), 64'd0);
        chk("mid_rst_result4", res4, 64'd0);
        chk("mid_rst_req_ready4", 64'(rr4), 64'd1);
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk); #1;
            if (rv1 || rv4 || busy1 || busy4) seen = 1;
        end
        chk("discarded_op_stays_silent", 64'(seen), 64'd0);
        run_op(3'b100, 1'b0, 64'd100, 64'd7, 1'b1, r1, r4, l1, l4, bok);
        chk("post_rst_div_result1", r1, 64'd14);
        chk("post_rst_div_result4", r4, 64'd14);
        chk("post_rst_div_latency1", 64'(l1), 64'd66);
        chk("post_rst_div_latency4", 64'(l4), 64'd18);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            w  = (f3 == 3'b000 || f3[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            a  = rand_op();
            b  = rand_op();
            e  = ref_res(f3, w, a, b);
            run_op(f3, w, a, b, 1'b1, r1, r4, l1, l4, bok);
            chk($sformatf("rnd%0d_f3_%0d_w%0d_result_u1", i, f3, w), r1, e);
            chk($sformatf("rnd%0d_f3_%0d_w%0d_result_u4", i, f3, w), r4, e);
            chk($sformatf("rnd%0d_latency_u1", i), 64'(l1), 64'(exp_lat(f3, w, a, b, 1)));
            chk($sformatf("rnd%0d_latency_u4", i), 64'(l4), 64'(exp_lat(f3, w, a, b, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
